video_in_capture: RTL and testbench
===================================

VIDEO_IN_CAPTURE -- requirements
Module: video_in_capture

Interface
REQ-001 SHALL have parameter P_WIDTH, default 640, active pixels per line; a multiple of 4.
REQ-002 SHALL have parameter P_HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_in  input  1  pixel clock from the source, asynchronous to clk, period >= 8 clk periods.
REQ-006 SHALL have port pixel_in  input  8  pixel byte, changed by the source on the clk_in rising edge.
REQ-007 SHALL have port frame_valid  input  1  frame active, changed on the clk_in rising edge.
REQ-008 SHALL have port line_valid  input  1  line active, changed on the clk_in rising edge.
REQ-009 SHALL have port w_data  output  32  packed word for the FIFO.
REQ-010 SHALL have port w_en  output  1  one-clk FIFO write strobe.
REQ-011 SHALL have port fifo_full  input  1  FIFO cannot accept a write.
REQ-012 SHALL have port frame_start  output  1  one-clk pulse when a frame is accepted.
REQ-013 SHALL have port frame_done  output  1  one-clk pulse when a complete, correct frame ends.
REQ-014 SHALL have port frame_err  output  1  one-clk pulse when a frame is aborted.
REQ-015 SHALL have port overflow  output  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-016 SHALL synchronise clk_in through 2 flops plus 1 history flop; a sample event (SE) is a detected falling edge of clk_in (history=1, sync=0).
REQ-017 SHALL capture pixel_in, frame_valid and line_valid directly, without synchronisers, on the clk cycle SE is detected; these are the samples.
REQ-018 SHALL implement FSM states IDLE, ACTIVE and DROP; all decisions are taken only on SE.
REQ-019 IDLE: on a sample with frame_valid=1 whose previous sampled frame_valid=0 -> ACTIVE, pulse frame_start, clear column, line and pack counters, clear overflow; a frame already in progress at reset exit SHALL be ignored.
REQ-020 ACTIVE, sample with line_valid=1: store pixel in byte lane pack_cnt (pixel 0 -> w_data[7:0], pixel 3 -> w_data[31:24]); increment column count and pack_cnt, which wraps 3->0.
REQ-021 On the 4th pixel of a group, w_en SHALL be high on the next clk cycle with the complete word for exactly 1 clk, unless fifo_full is high on that cycle, in which case the word is dropped and overflow is set; the capture continues.
REQ-022 ACTIVE, line_valid falling between samples: if column count == P_WIDTH, increment line count and clear column count; otherwise pulse frame_err and go to DROP.
REQ-023 ACTIVE, line_valid=1 with column count already == P_WIDTH (line too long) SHALL pulse frame_err and go to DROP.
REQ-024 ACTIVE, frame_valid falling: if line count == P_HEIGHT and line_valid was low, pulse frame_done and go to IDLE; otherwise pulse frame_err and go to IDLE.
REQ-025 ACTIVE, line count == P_HEIGHT and line_valid rising (extra line) SHALL pulse frame_err and go to DROP.
REQ-026 DROP: no writes; on a sample with frame_valid=0 -> IDLE.
REQ-027 Counters SHALL be 10 bits (column, line) and 2 bits (pack_cnt); column and line counts never exceed P_WIDTH and P_HEIGHT.
REQ-028 frame_done and frame_err SHALL never be asserted together; at most one of frame_start, frame_done and frame_err fires per SE.
REQ-029 overflow SHALL hold until the next frame_start or reset.

Reset
REQ-030 nRST low SHALL asynchronously force state IDLE; all counters, synchroniser flops and the previous-frame_valid register 0; w_data 0; w_en, frame_start, frame_done, frame_err and overflow 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial word; after release, capture resumes only at the next frame_valid rising edge.

Verification (P_WIDTH=8, P_HEIGHT=2, clk_in = clk/10)
REQ-032 Full frame of pixels 0x00..0x0F -> frame_start once; 4 w_en pulses with 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; then frame_done once.
REQ-033 Line 1 has only 6 pixels -> 1 word written for it, frame_err pulse, no further w_en until the next frame_start.
REQ-034 fifo_full held high during the 2nd word's strobe -> words 1, 3 and 4 written, overflow=1 until the next frame_start.
REQ-035 Release nRST while frame_valid=1 -> no writes for that frame; the next frame is captured normally with frame_done.
REQ-036 frame_valid falls after 1 line -> frame_err pulse, state IDLE, no frame_done.

Source files
------------

// File: rtl/video_in_capture.sv
// Video input capture: samples a slow, asynchronous parallel camera bus on
// the falling edge of its pixel clock, checks the frame geometry against
// P_WIDTH x P_HEIGHT and packs four pixels into each 32-bit FIFO word.
module video_in_capture #(
  parameter int P_WIDTH  = 640,
  parameter int P_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clk_in,
  input  logic [7:0]  pixel_in,
  input  logic        frame_valid,
  input  logic        line_valid,
  output logic [31:0] w_data,
  output logic        w_en,
  input  logic        fifo_full,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow
);

  localparam logic [9:0] WIDTH_C  = 10'(P_WIDTH);
  localparam logic [9:0] HEIGHT_C = 10'(P_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t     state_q, state_d;

  // clk_in synchroniser (p0, p1) and edge history (p2)
  logic       clk_in_p0, clk_in_p1, clk_in_p2;
  logic       se;

  logic [9:0] col_q, col_d;
  logic [9:0] line_q, line_d;
  logic [1:0] pack_q, pack_d;
  logic       fv_prev_q, lv_prev_q;
  // Set by the first sample after reset, so a frame already running at
  // reset exit never looks like a fresh frame_valid rising edge.
  logic       primed_q;

  logic       start_d, done_d, err_d;
  logic       lane_we, word_done, ovf_clr;
  // A completed word waits one cycle here before being offered to the FIFO
  logic       vld_p1;

  // Falling edge of the synchronised pixel clock; the bus is stable by then
  assign se   = clk_in_p2 & ~clk_in_p1;
  assign w_en = vld_p1 & ~fifo_full;

  // Pixel clock synchroniser and history flop
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      clk_in_p0 <= 1'b0;
      clk_in_p1 <= 1'b0;
      clk_in_p2 <= 1'b0;
    end else begin
      clk_in_p0 <= clk_in;
      clk_in_p1 <= clk_in_p0;
      clk_in_p2 <= clk_in_p1;
    end
  end

  // Frame/line FSM: next state, counters and event pulses, decided only on SE
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    pack_d    = pack_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    lane_we   = 1'b0;
    word_done = 1'b0;
    ovf_clr   = 1'b0;
    if (se) begin
      case (state_q)
        IDLE: begin
          if (frame_valid && !fv_prev_q && primed_q) begin
            state_d = ACTIVE;
            start_d = 1'b1;
            col_d   = 10'd0;
            line_d  = 10'd0;
            pack_d  = 2'd0;
            ovf_clr = 1'b1;
          end
        end
        ACTIVE: begin
          if (!frame_valid) begin
            // End of frame: complete only with every line seen and the
            // last line already closed before frame_valid dropped.
            state_d = IDLE;
            if (line_q == HEIGHT_C && !lv_prev_q) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (line_valid) begin
            if ((!lv_prev_q && line_q == HEIGHT_C) || col_q == WIDTH_C) begin
              // extra line, or line longer than P_WIDTH
              state_d = DROP;
              err_d   = 1'b1;
            end else begin
              lane_we   = 1'b1;
              col_d     = col_q + 10'd1;
              pack_d    = pack_q + 2'd1;
              word_done = (pack_q == 2'd3);
            end
          end else if (lv_prev_q) begin
            if (col_q == WIDTH_C) begin
              col_d  = 10'd0;
              line_d = line_q + 10'd1;
            end else begin
              state_d = DROP;
              err_d   = 1'b1;
            end
          end
        end
        DROP: begin
          if (!frame_valid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, counters, input history, pulses and sticky overflow
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      col_q       <= 10'd0;
      line_q      <= 10'd0;
      pack_q      <= 2'd0;
      fv_prev_q   <= 1'b0;
      lv_prev_q   <= 1'b0;
      primed_q    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      vld_p1      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      line_q      <= line_d;
      pack_q      <= pack_d;
      frame_start <= start_d;
      frame_done  <= done_d;
      frame_err   <= err_d;
      vld_p1      <= word_done;
      if (se) begin
        fv_prev_q <= frame_valid;
        lv_prev_q <= line_valid;
        primed_q  <= 1'b1;
      end
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (vld_p1 && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Pixel packing: each accepted pixel lands in byte lane pack_q
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      w_data <= 32'd0;
    end else if (lane_we) begin
      w_data[{pack_q, 3'b000} +: 8] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_video_in_capture.sv
// Bench for video_in_capture at 8x2 pixels, pixel clock = clk/10.
// Directed vector table (one record per pixel-clock period) followed by
// randomised frames checked against a frame-level reference model.
module tb_video_in_capture;

  localparam int W = 8;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        clk_in = 1'b0;
  logic [7:0]  pixel_in = 8'd0;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic [31:0] w_data;
  logic        w_en;
  logic        fifo_full = 1'b0;
  logic        frame_start, frame_done, frame_err, overflow;

  video_in_capture #(.P_WIDTH(W), .P_HEIGHT(H)) dut (
    .clk(clk), .nRST(nRST), .clk_in(clk_in), .pixel_in(pixel_in),
    .frame_valid(frame_valid), .line_valid(line_valid),
    .w_data(w_data), .w_en(w_en), .fifo_full(fifo_full),
    .frame_start(frame_start), .frame_done(frame_done),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Output monitor, sampled on the inactive clock edge
  int          tot_start = 0, tot_done = 0, tot_err = 0, tot_wen = 0, excl = 0;
  logic [31:0] last_word = 32'd0;
  logic [31:0] wq[$];

  always @(negedge clk) begin
    if (w_en) begin
      tot_wen   <= tot_wen + 1;
      last_word <= w_data;
      wq.push_back(w_data);
    end
    if (frame_start) tot_start <= tot_start + 1;
    if (frame_done)  tot_done  <= tot_done + 1;
    if (frame_err)   tot_err   <= tot_err + 1;
    if ((frame_done && frame_err) ||
        (int'(frame_start) + int'(frame_done) + int'(frame_err) > 1))
      excl <= excl + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pixel-clock period: source drives on the rising edge
  task automatic pix(input logic fv, input logic lv, input logic [7:0] d, input logic full);
    clk_in      = 1'b1;
    frame_valid = fv;
    line_valid  = lv;
    pixel_in    = d;
    fifo_full   = full;
    #50;
    clk_in = 1'b0;
    #50;
  endtask

  task automatic chk_reset_state();
    chk("rst_wdata", w_data, 32'd0);
    chk("rst_ctl", 32'({w_en, frame_start, frame_done, frame_err}), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fv, lv;
    logic [7:0]  d;
    logic        full, rst;
    logic        es, ed, ee, ew;
    logic [31:0] word;
    logic        ovf;
  } vec_t;

  vec_t vq[$];
  logic b_ovf = 1'b0;

  function automatic void add(input logic fv, input logic lv, input logic [7:0] d,
                              input logic full, input logic rst, input logic es,
                              input logic ed, input logic ee, input logic ew,
                              input logic [31:0] word);
    vec_t v;
    v.fv = fv; v.lv = lv; v.d = d; v.full = full; v.rst = rst;
    v.es = es; v.ed = ed; v.ee = ee; v.ew = ew; v.word = word; v.ovf = b_ovf;
    vq.push_back(v);
  endfunction

  function automatic void add_none(input logic fv, input logic lv);
    add(fv, lv, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endfunction

  function automatic void add_start();
    b_ovf = 1'b0;
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endfunction

  // n pixels base..base+n-1; every 4th pixel completes a word unless the
  // FIFO is full during that period (full_at = pixel index, -1 = never)
  function automatic void add_pix(input int base, input int n, input int full_at);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      logic       full, ew;
      d    = 8'(base + i);
      full = (i == full_at);
      ew   = ((i % 4) == 3) && !full;
      if (full) b_ovf = 1'b1;
      add(1'b1, 1'b1, d, full, 1'b0, 1'b0, 1'b0, 1'b0, ew,
          {d, d - 8'd1, d - 8'd2, d - 8'd3});
    end
  endfunction

  function automatic void add_quiet(input int base, input int n);
    for (int i = 0; i < n; i++)
      add(1'b1, 1'b1, 8'(base + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endfunction

  function automatic void add_good_frame(input int base, input int full_at);
    add_start();
    add_pix(base, W, full_at);
    add_none(1'b1, 1'b0);
    add_pix(base + W, W, -1);
    add_none(1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endfunction

  function automatic void build_table();
    add_none(1'b0, 1'b0);                    // idle sample after reset
    add_good_frame(0, -1);                   // full frame 0x00..0x0F
    add_good_frame(0, 7);                    // FIFO full on the 2nd word
    // second line only 6 pixels
    add_start();
    add_pix(0, W, -1);
    add_none(1'b1, 1'b0);
    add_pix(8, 6, -1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_quiet(8'h20, 4);
    add_none(1'b1, 1'b0);
    add_none(1'b0, 1'b0);
    // frame_valid falls after one line, next frame starts straight away
    add_start();
    add_pix(0, W, -1);
    add_none(1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_good_frame(8'h40, -1);
    // reset mid-frame, released while frame_valid is still high
    add_start();
    add_pix(0, 6, -1);
    add(1'b1, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    add_quiet(7, 1);
    add_none(1'b1, 1'b0);
    add_quiet(8, 8);
    add_none(1'b1, 1'b0);
    add_none(1'b0, 1'b0);
    add_good_frame(8'h80, -1);
    // line too long: 9th pixel aborts
    add_start();
    add_pix(0, W, -1);
    add(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_none(1'b1, 1'b0);
    add_none(1'b0, 1'b0);
    // extra line after P_HEIGHT lines
    add_start();
    add_pix(0, W, -1);
    add_none(1'b1, 1'b0);
    add_pix(8, W, -1);
    add_none(1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_quiet(8'h56, 2);
    add_none(1'b1, 1'b0);
    add_none(1'b0, 1'b0);
  endfunction

  task automatic run_table();
    for (int k = 0; k < vq.size(); k++) begin
      vec_t v;
      int   s_start, s_done, s_err, s_wen;
      int   ds, dd, de, dw;
      v = vq[k];
      if (v.rst) begin
        nRST = 1'b0;
        #1;
        chk_reset_state();
        #4;
        nRST = 1'b1;
      end
      s_start = tot_start; s_done = tot_done; s_err = tot_err; s_wen = tot_wen;
      pix(v.fv, v.lv, v.d, v.full);
      ds = tot_start - s_start; dd = tot_done - s_done;
      de = tot_err - s_err;     dw = tot_wen - s_wen;
      chk($sformatf("vec%0d_pulses", k), {8'(ds), 8'(dd), 8'(de), 8'(dw)},
          {7'b0, v.es, 7'b0, v.ed, 7'b0, v.ee, 7'b0, v.ew});
      if (v.ew) chk($sformatf("vec%0d_word", k), last_word, v.word);
      chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'(v.ovf));
    end
  endtask

  // ---------------- randomised frames vs frame-level model ----------------
  task automatic run_random_frame(input int idx);
    int         kind, nl, li, base_w, nexp;
    int         lens[3];
    logic [7:0] px[3][11];
    logic [7:0] exp_px[$];
    bit         bad;
    int         s_start, s_done, s_err;

    kind = $urandom_range(0, 4);
    nl = H;
    lens[0] = W; lens[1] = W; lens[2] = W;
    li = $urandom_range(0, 1);
    case (kind)
      1: lens[li] = $urandom_range(1, W - 1);
      2: lens[li] = $urandom_range(W + 1, W + 2);
      3: nl = 1;
      4: nl = 3;
      default: ;
    endcase
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 11; i++)
        px[l][i] = 8'($urandom);

    base_w  = wq.size();
    s_start = tot_start; s_done = tot_done; s_err = tot_err;
    pix(1'b1, 1'b0, 8'h00, 1'b0);
    repeat ($urandom_range(0, 1)) pix(1'b1, 1'b0, 8'h00, 1'b0);
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < lens[l]; i++) pix(1'b1, 1'b1, px[l][i], 1'b0);
      repeat ($urandom_range(1, 2)) pix(1'b1, 1'b0, 8'h00, 1'b0);
    end
    pix(1'b0, 1'b0, 8'h00, 1'b0);
    repeat ($urandom_range(0, 1)) pix(1'b0, 1'b0, 8'h00, 1'b0);

    // Reference: accept lines in order until the first geometry violation
    bad = 1'b0;
    for (int l = 0; l < nl; l++) begin
      if (l >= H) begin bad = 1'b1; break; end
      for (int i = 0; i < lens[l] && i < W; i++) exp_px.push_back(px[l][i]);
      if (lens[l] != W) begin bad = 1'b1; break; end
    end
    if (!bad && nl < H) bad = 1'b1;
    nexp = exp_px.size() / 4;

    chk($sformatf("rnd%0d_k%0d_start", idx, kind), 32'(tot_start - s_start), 32'd1);
    chk($sformatf("rnd%0d_k%0d_done", idx, kind), 32'(tot_done - s_done), 32'(!bad));
    chk($sformatf("rnd%0d_k%0d_err", idx, kind), 32'(tot_err - s_err), 32'(bad));
    chk($sformatf("rnd%0d_k%0d_nwords", idx, kind), 32'(wq.size() - base_w), 32'(nexp));
    for (int k = 0; k < nexp && base_w + k < wq.size(); k++)
      chk($sformatf("rnd%0d_word%0d", idx, k), wq[base_w + k],
          {exp_px[4*k+3], exp_px[4*k+2], exp_px[4*k+1], exp_px[4*k]});
  endtask

  initial begin
    build_table();
    #2;
    chk_reset_state();
    #20;
    nRST = 1'b1;
    #1;
    run_table();
    for (int f = 0; f < 24; f++) run_random_frame(f);
    chk("exclusive_pulses", 32'(excl), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
